calendar_bcd_sched: RTL and testbench

Calendar date register (day/month/year) for the century clock. Advances one day per `day_tick` and rolls over using the leap-year rule. Time-shares one combinational binary-to-BCD encoder across the year, month and day fields to produce registered BCD display digits and a registered leap flag. Sits between the time-of-day counter, which supplies `day_tick`, and the display/mux logic; a valid/ready port loads a new date.

---
 rtl/calendar_bcd_sched_pkg.sv | 29 ++
 rtl/calendar_bcd_sched_bin2bcd14.sv | 25 ++
 rtl/calendar_bcd_sched.sv | 185 ++++++++++++++++++
 tb/tb_calendar_bcd_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_bcd_sched_pkg.sv
// cal_pkg: shared types and constants for the calendar date register.
//   state_t    - conversion scheduler states
//   MAX_YEAR   - highest representable year (wraps to 0 after it)
//   MIN_DAY    - first day of every month
//   month_len  - number of days in a month for a given leap flag
package cal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV_YEAR,
    CONV_MONTH,
    CONV_DAY
  } state_t;

  localparam int unsigned MAX_YEAR = 9999;
  localparam logic [4:0] MIN_DAY   = 5'd1;
  localparam logic [4:0] LEN_LONG  = 5'd31;
  localparam logic [4:0] LEN_SHORT = 5'd30;
  localparam logic [4:0] LEN_FEB   = 5'd28;

  function automatic logic [4:0] month_len(input logic [3:0] month, input logic leap_yr);
    case (month)
      4'd2:                    month_len = leap_yr ? LEN_FEB + 5'd1 : LEN_FEB;
      4'd4, 4'd6, 4'd9, 4'd11: month_len = LEN_SHORT;
      default:                 month_len = LEN_LONG;
    endcase
  endfunction

endpackage

// File: rtl/calendar_bcd_sched_bin2bcd14.sv
// bin2bcd14: combinational double-dabble binary-to-BCD encoder.
//   i_bin [13:0] - binary value (0..9999 meaningful)
//   o_bcd [15:0] - {thousands, hundreds, tens, units}
module bin2bcd14
  import cal_pkg::*;
(
  input  logic [13:0] i_bin,
  output logic [15:0] o_bcd
);

  always_comb begin
    logic [15:0] w_acc;
    w_acc = '0;
    for (int unsigned i = 0; i < 14; i++) begin
      for (int unsigned d = 0; d < 4; d++) begin
        if (w_acc[4*d +: 4] >= 4'd5) begin
          w_acc[4*d +: 4] = w_acc[4*d +: 4] + 4'd3;
        end
      end
      w_acc = {w_acc[14:0], i_bin[13 - i]};
    end
    o_bcd = w_acc;
  end

endmodule

// File: rtl/calendar_bcd_sched.sv
// calendar_bcd_sched: day/month/year register with leap-year rollover and a
// time-shared BCD encoder producing registered display digits.
//   clk, rst               - clock, async active-high reset
//   day_tick               - advance one day
//   set_valid/set_ready    - load handshake for set_day/set_month/set_year
//   set_err                - pulse: load rejected
//   day_bin/month_bin/year_bin - current binary date
//   day_bcd/month_bcd/year_bcd - registered BCD digits
//   leap                   - registered leap flag of year_bin
//   bcd_valid              - BCD outputs and leap match the binary fields
//   tick_lost              - pulse: a day_tick was discarded
module calendar_bcd_sched
  import cal_pkg::*;
#(
  parameter int unsigned YEAR_W   = 14,
  parameter int unsigned RST_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              day_tick,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [4:0]        set_day,
  input  logic [3:0]        set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_err,
  output logic [4:0]        day_bin,
  output logic [3:0]        month_bin,
  output logic [YEAR_W-1:0] year_bin,
  output logic [7:0]        day_bcd,
  output logic [7:0]        month_bcd,
  output logic [15:0]       year_bcd,
  output logic              leap,
  output logic              bcd_valid,
  output logic              tick_lost
);

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_day, w_day_nxt;
  logic [3:0]        r_month, w_month_nxt;
  logic [YEAR_W-1:0] r_year, w_year_nxt;
  logic [7:0]        r_day_bcd, r_month_bcd;
  logic [15:0]       r_year_bcd;
  logic              r_leap, r_pending, r_set_err, r_tick_lost;
  logic              w_pending_nxt, w_set_err_nxt, w_tick_lost_nxt, w_advance;
  logic [13:0]       w_enc_in;
  logic [15:0]       w_enc_bcd;
  logic [5:0]        w_cent;
  logic              w_leap_calc, w_set_ok;
  logic [4:0]        w_lim;

  always_comb begin
    case (r_state)
      CONV_YEAR:  w_enc_in = 14'(r_year);
      CONV_MONTH: w_enc_in = {10'd0, r_month};
      default:    w_enc_in = {9'd0, r_day};
    endcase
  end

  bin2bcd14 u_enc (
    .i_bin (w_enc_in),
    .o_bcd (w_enc_bcd)
  );

  // Century years: year/100 mod 4 == (2*thousands + hundreds) mod 4.
  assign w_cent      = {1'b0, w_enc_bcd[15:12], 1'b0} + {2'b00, w_enc_bcd[11:8]};
  assign w_leap_calc = (r_year[1:0] == 2'b00) &&
                       !((w_enc_bcd[7:0] == 8'h00) && (w_cent[1:0] != 2'b00));

  // Feb is checked against 29 here; a non-leap Feb 29 is trimmed in CONV_YEAR.
  assign w_set_ok = (set_month >= 4'd1) && (set_month <= 4'd12) &&
                    (set_day >= MIN_DAY) && (32'(set_year) <= MAX_YEAR) &&
                    (set_day <= month_len(set_month, 1'b1));

  assign w_lim = month_len(r_month, r_leap);

  always_comb begin
    w_state_nxt     = r_state;
    w_day_nxt       = r_day;
    w_month_nxt     = r_month;
    w_year_nxt      = r_year;
    w_pending_nxt   = r_pending;
    w_set_err_nxt   = 1'b0;
    w_tick_lost_nxt = 1'b0;
    w_advance       = 1'b0;

    case (r_state)
      IDLE: begin
        if (r_pending) begin
          w_advance     = 1'b1;
          w_pending_nxt = day_tick;
        end else if (set_valid) begin
          w_tick_lost_nxt = day_tick;
          if (w_set_ok) begin
            w_day_nxt   = set_day;
            w_month_nxt = set_month;
            w_year_nxt  = set_year;
            w_state_nxt = CONV_YEAR;
          end else begin
            w_set_err_nxt = 1'b1;
          end
        end else if (day_tick) begin
          w_advance = 1'b1;
        end
      end
      CONV_YEAR: begin
        w_state_nxt = CONV_MONTH;
        if (!w_leap_calc && (r_month == 4'd2) && (r_day == 5'd29)) begin
          w_day_nxt = 5'd28;
        end
      end
      CONV_MONTH: w_state_nxt = CONV_DAY;
      default:    w_state_nxt = IDLE;
    endcase

    if ((r_state != IDLE) && day_tick) begin
      if (r_pending) w_tick_lost_nxt = 1'b1;
      else           w_pending_nxt   = 1'b1;
    end

    if (w_advance) begin
      w_state_nxt = CONV_YEAR;
      if (r_day < w_lim) begin
        w_day_nxt = r_day + 5'd1;
      end else begin
        w_day_nxt = MIN_DAY;
        if (r_month == 4'd12) begin
          w_month_nxt = 4'd1;
          w_year_nxt  = (r_year == YEAR_W'(MAX_YEAR)) ? '0 : r_year + YEAR_W'(1);
        end else begin
          w_month_nxt = r_month + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CONV_YEAR;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_day       <= MIN_DAY;
      r_month     <= 4'd1;
      r_year      <= YEAR_W'(RST_YEAR);
      r_day_bcd   <= '0;
      r_month_bcd <= '0;
      r_year_bcd  <= '0;
      r_leap      <= 1'b0;
      r_pending   <= 1'b0;
      r_set_err   <= 1'b0;
      r_tick_lost <= 1'b0;
    end else begin
      r_day       <= w_day_nxt;
      r_month     <= w_month_nxt;
      r_year      <= w_year_nxt;
      r_pending   <= w_pending_nxt;
      r_set_err   <= w_set_err_nxt;
      r_tick_lost <= w_tick_lost_nxt;
      case (r_state)
        CONV_YEAR: begin
          r_year_bcd <= w_enc_bcd;
          r_leap     <= w_leap_calc;
        end
        CONV_MONTH: r_month_bcd <= w_enc_bcd[7:0];
        CONV_DAY:   r_day_bcd   <= w_enc_bcd[7:0];
        default: ;
      endcase
    end
  end

  assign set_ready = (r_state == IDLE) && !r_pending;
  assign bcd_valid = (r_state == IDLE);
  assign set_err   = r_set_err;
  assign tick_lost = r_tick_lost;
  assign day_bin   = r_day;
  assign month_bin = r_month;
  assign year_bin  = r_year;
  assign day_bcd   = r_day_bcd;
  assign month_bcd = r_month_bcd;
  assign year_bcd  = r_year_bcd;
  assign leap      = r_leap;

endmodule

// File: tb/tb_calendar_bcd_sched.sv
module tb_calendar_bcd_sched;

  localparam int unsigned YEAR_W = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic              day_tick, set_valid, set_ready, set_err;
  logic [4:0]        set_day, day_bin;
  logic [3:0]        set_month, month_bin;
  logic [YEAR_W-1:0] set_year, year_bin;
  logic [7:0]        day_bcd, month_bcd;
  logic [15:0]       year_bcd;
  logic              leap, bcd_valid, tick_lost;

  always #5 clk = ~clk;

  calendar_bcd_sched #(.YEAR_W(YEAR_W), .RST_YEAR(2000)) dut (
    .clk(clk), .rst(rst), .day_tick(day_tick),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_day(set_day), .set_month(set_month), .set_year(set_year),
    .set_err(set_err), .day_bin(day_bin), .month_bin(month_bin),
    .year_bin(year_bin), .day_bcd(day_bcd), .month_bcd(month_bcd),
    .year_bcd(year_bcd), .leap(leap), .bcd_valid(bcd_valid),
    .tick_lost(tick_lost)
  );

  typedef enum int {EV_DATE, EV_ERR, EV_LOST} ev_kind_t;
  typedef struct {ev_kind_t kind; int d; int m; int y;} ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  md, mm, my;   // reference date

  function automatic bit is_leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int mlen(input int m, input bit lp);
    if (m == 2) return lp ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    return 31;
  endfunction

  function automatic int to_bcd(input int v);
    return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
           (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_t k);
    ev_t e;
    e.kind = k; e.d = md; e.m = mm; e.y = my;
    exp_q.push_back(e);
  endtask

  task automatic model_tick();
    if (md < mlen(mm, is_leap(my))) md++;
    else begin
      md = 1;
      if (mm == 12) begin
        mm = 1;
        my = (my == 9999) ? 0 : my + 1;
      end else mm++;
    end
  endtask

  // Monitor: pops one expectation per observed DUT event.
  task automatic expect_event(input ev_kind_t k);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", int'(k), $time);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", int'(k), int'(e.kind));
    if (k != EV_LOST) begin
      chk("day_bin", int'(day_bin), e.d);
      chk("month_bin", int'(month_bin), e.m);
      chk("year_bin", int'(year_bin), e.y);
    end
    if (k == EV_DATE) begin
      chk("day_bcd", int'(day_bcd), to_bcd(e.d));
      chk("month_bcd", int'(month_bcd), to_bcd(e.m));
      chk("year_bcd", int'(year_bcd), to_bcd(e.y));
      chk("leap", int'(leap), int'(is_leap(e.y)));
    end
  endtask

  logic prev_bv = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_bv = 1'b0;
    else begin
      if (set_err) expect_event(EV_ERR);
      if (tick_lost) expect_event(EV_LOST);
      if (bcd_valid && !prev_bv) expect_event(EV_DATE);
      prev_bv = bcd_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!set_ready && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", int'(set_ready), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_day", int'(day_bin), 1);
    chk("rst_month", int'(month_bin), 1);
    chk("rst_year", int'(year_bin), 2000);
    chk("rst_day_bcd", int'(day_bcd), 0);
    chk("rst_month_bcd", int'(month_bcd), 0);
    chk("rst_year_bcd", int'(year_bcd), 0);
    chk("rst_leap", int'(leap), 0);
    chk("rst_bcd_valid", int'(bcd_valid), 0);
    chk("rst_set_err", int'(set_err), 0);
    chk("rst_tick_lost", int'(tick_lost), 0);
    chk("rst_set_ready", int'(set_ready), 0);
  endtask

  // Release reset and confirm the first conversion finishes after three edges.
  task automatic release_reset();
    exp_q.delete();
    md = 1; mm = 1; my = 2000;
    push(EV_DATE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bcd_valid_early", int'(bcd_valid), 0);
    @(posedge clk); #1;
    chk("bcd_valid_after_reset", int'(bcd_valid), 1);
  endtask

  task automatic do_op(input bit is_set, input int d, input int m, input int y,
                       input bit simul, input int mask);
    bit valid;
    int k;
    wait_ready();
    if (is_set) begin
      valid = (m >= 1) && (m <= 12) && (d >= 1) && (d <= mlen(m, 1'b1)) && (y <= 9999);
      if (!valid) begin
        push(EV_ERR);
        if (simul) push(EV_LOST);
        mask = 0;
      end else begin
        if (simul) push(EV_LOST);
        md = d; mm = m; my = y;
        if (!is_leap(y) && m == 2 && d == 29) md = 28;
      end
    end else begin
      simul = 1'b0;
      valid = 1'b1;
      model_tick();
    end
    if (valid) begin
      k = $countones(mask[2:0]);
      for (int i = 1; i < k; i++) push(EV_LOST);
      push(EV_DATE);
      if (k >= 1) begin
        model_tick();
        push(EV_DATE);
      end
    end
    set_valid = is_set;
    set_day   = d[4:0];
    set_month = m[3:0];
    set_year  = y[YEAR_W-1:0];
    day_tick  = !is_set || simul;
    @(posedge clk); #1;
    set_valid = 1'b0;
    day_tick  = 1'b0;
    if (valid) begin
      for (int j = 0; j < 3; j++) begin
        day_tick = mask[j];
        @(posedge clk); #1;
      end
      day_tick = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int r, d, m, y, mask;
    bit simul;
    rst = 1'b1; day_tick = 1'b0; set_valid = 1'b0;
    set_day = '0; set_month = '0; set_year = '0;
    #2;
    chk_reset_vals();
    release_reset();

    // Leap-year rollover cases
    do_op(1'b1, 28, 2, 2100, 1'b0, 0);
    do_op(1'b0, 0, 0, 0, 1'b0, 0);
    do_op(1'b1, 28, 2, 2000, 1'b0, 0);
    do_op(1'b0, 0, 0, 0, 1'b0, 0);
    do_op(1'b0, 0, 0, 0, 1'b0, 0);
    do_op(1'b1, 31, 12, 9999, 1'b0, 0);
    do_op(1'b0, 0, 0, 0, 1'b0, 0);
    // Feb 29 trimmed in a non-leap year; rejects
    do_op(1'b1, 29, 2, 2023, 1'b0, 0);
    do_op(1'b1, 10, 13, 2023, 1'b0, 0);
    do_op(1'b1, 31, 4, 2023, 1'b0, 0);
    do_op(1'b1, 30, 2, 2024, 1'b0, 0);
    do_op(1'b1, 1, 1, 10000, 1'b0, 0);
    do_op(1'b1, 0, 1, 2024, 1'b0, 0);
    // Ticks colliding with sets and conversions
    do_op(1'b1, 10, 5, 2024, 1'b0, 1);
    do_op(1'b0, 0, 0, 0, 1'b0, 3);
    do_op(1'b0, 0, 0, 0, 1'b0, 7);
    do_op(1'b1, 1, 6, 2030, 1'b1, 0);
    do_op(1'b1, 31, 6, 2030, 1'b1, 0);
    do_op(1'b1, 29, 2, 1900, 1'b0, 4);

    // Reset during CONV_MONTH after a set
    wait_ready();
    set_valid = 1'b1; set_day = 5'd15; set_month = 4'd7; set_year = 14'd2024;
    @(posedge clk); #1;
    set_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_reset_vals();
    release_reset();

    // Randomized traffic
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      mask = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
      if (r < 50) begin
        do_op(1'b0, 0, 0, 0, 1'b0, mask);
      end else begin
        m = $urandom_range(1, 12);
        d = ($urandom_range(0, 1) != 0) ? $urandom_range(27, 31) : $urandom_range(1, 31);
        case ($urandom_range(0, 5))
          0:       y = 1900 + 100 * $urandom_range(0, 5);
          1:       y = 9999;
          default: y = $urandom_range(0, 9999);
        endcase
        if (r >= 92) begin
          case ($urandom_range(0, 3))
            0:       m = $urandom_range(13, 15);
            1:       m = 0;
            2:       d = 0;
            default: y = $urandom_range(10000, 16383);
          endcase
        end
        simul = ($urandom_range(0, 4) == 0);
        do_op(1'b1, d, m, y, simul, mask);
      end
    end

    wait_ready();
    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
